clint_arb: RTL and testbench

//  Parametrised core-local trap arbiter. Arbitrates NUM_IRQ maskable level interrupts, ECALL/EBREAK and

---
 rtl/clint_arb.sv | 207 ++++++++++++++++++++
 tb/tb_clint_arb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/clint_arb.sv
// Core-local trap arbiter: picks ECALL/EBREAK, masked level IRQs or MRET in ID,
// sequences mepc/mcause/mstatus writes over one CSR port, then pulses a redirect.
module clint_arb #(
  parameter int unsigned NUM_IRQ     = 4,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CAUSE_BASE  = 16,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               inst_valid_i,
  input  logic [31:0]        inst_i,
  input  logic [XLEN-1:0]    inst_addr_i,
  input  logic               jump_flag_i,
  input  logic [XLEN-1:0]    jump_addr_i,
  input  logic [XLEN-1:0]    csr_mtvec_i,
  input  logic [XLEN-1:0]    csr_mepc_i,
  input  logic [XLEN-1:0]    csr_mstatus_i,
  output logic               hold_o,
  output logic               csr_we_o,
  output logic [11:0]        csr_waddr_o,
  output logic [XLEN-1:0]    csr_wdata_o,
  output logic               int_assert_o,
  output logic [XLEN-1:0]    int_addr_o,
  output logic [NUM_IRQ-1:0] irq_ack_o
);

  localparam int unsigned SRC_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MSTATUS,
    S_W_MRET,
    S_ASSERT
  } state_t;

  state_t             r_state;
  logic [XLEN-1:0]    r_epc;
  logic [XLEN-1:0]    r_cause;
  logic [SRC_W-1:0]   r_src;
  logic               r_async;

  logic               r_csr_we;
  logic [11:0]        r_csr_waddr;
  logic [XLEN-1:0]    r_csr_wdata;
  logic               r_int_assert;
  logic [XLEN-1:0]    r_int_addr;
  logic [NUM_IRQ-1:0] r_irq_ack;

  logic [NUM_IRQ-1:0] w_pend;
  logic               w_is_ecall;
  logic               w_is_ebreak;
  logic               w_is_mret;
  logic               w_sync;
  logic               w_async;
  logic               w_mret;
  logic               w_detect;
  logic [SRC_W-1:0]   w_src;
  logic [XLEN-1:0]    w_irq_cause;
  logic [XLEN-1:0]    w_sync_cause;
  logic [XLEN-1:0]    w_async_epc;
  logic [XLEN-1:0]    w_mst_trap;
  logic [XLEN-1:0]    w_mst_mret;
  logic [XLEN-1:0]    w_vec_off;
  logic               w_vectored;
  logic [XLEN-1:0]    w_trap_tgt;
  logic [NUM_IRQ-1:0] w_ack;

  // Request decode for the IDLE arbitration.
  assign w_pend      = irq_i & irq_en_i;
  assign w_is_ecall  = (inst_i == INST_ECALL);
  assign w_is_ebreak = (inst_i == INST_EBREAK);
  assign w_is_mret   = (inst_i == INST_MRET);
  assign w_sync      = inst_valid_i & (w_is_ecall | w_is_ebreak);
  assign w_async     = csr_mstatus_i[3] & (|w_pend);
  assign w_mret      = inst_valid_i & w_is_mret;
  assign w_detect    = w_sync | w_async | w_mret;

  assign hold_o = rst_n & ((r_state != S_IDLE) | w_detect);

  // Lowest pending index wins.
  always_comb begin
    w_src = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_pend[i]) w_src = SRC_W'(i);
    end
  end

  assign w_irq_cause  = {1'b1, (XLEN-1)'(CAUSE_BASE) + (XLEN-1)'(w_src)};
  assign w_sync_cause = w_is_ecall ? XLEN'(11) : XLEN'(3);
  assign w_async_epc  = jump_flag_i ? jump_addr_i : inst_addr_i;

  always_comb begin
    w_mst_trap    = csr_mstatus_i;
    w_mst_trap[7] = csr_mstatus_i[3];
    w_mst_trap[3] = 1'b0;
    w_mst_mret    = csr_mstatus_i;
    w_mst_mret[3] = csr_mstatus_i[7];
    w_mst_mret[7] = 1'b1;
  end

  // Vector offset is 4*code; the interrupt flag drops out of the shift.
  assign w_vec_off  = {r_cause[XLEN-3:0], 2'b00};
  assign w_vectored = VECTORED_EN & (csr_mtvec_i[1:0] == 2'b01) & r_async;
  assign w_trap_tgt = {csr_mtvec_i[XLEN-1:2], 2'b00} + (w_vectored ? w_vec_off : '0);
  assign w_ack      = r_async ? (NUM_IRQ'(1) << r_src) : '0;

  // Outputs are loaded on the edge entering each state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_epc        <= '0;
      r_cause      <= '0;
      r_src        <= '0;
      r_async      <= 1'b0;
      r_csr_we     <= 1'b0;
      r_csr_waddr  <= '0;
      r_csr_wdata  <= '0;
      r_int_assert <= 1'b0;
      r_int_addr   <= '0;
      r_irq_ack    <= '0;
    end else begin
      r_csr_we     <= 1'b0;
      r_csr_waddr  <= '0;
      r_csr_wdata  <= '0;
      r_int_assert <= 1'b0;
      r_int_addr   <= '0;
      r_irq_ack    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_sync) begin
            r_epc       <= inst_addr_i;
            r_cause     <= w_sync_cause;
            r_src       <= '0;
            r_async     <= 1'b0;
            r_state     <= S_W_MEPC;
            r_csr_we    <= 1'b1;
            r_csr_waddr <= CSR_MEPC;
            r_csr_wdata <= inst_addr_i;
          end else if (w_async) begin
            r_epc       <= w_async_epc;
            r_cause     <= w_irq_cause;
            r_src       <= w_src;
            r_async     <= 1'b1;
            r_state     <= S_W_MEPC;
            r_csr_we    <= 1'b1;
            r_csr_waddr <= CSR_MEPC;
            r_csr_wdata <= w_async_epc;
          end else if (w_mret) begin
            r_state     <= S_W_MRET;
            r_csr_we    <= 1'b1;
            r_csr_waddr <= CSR_MSTATUS;
            r_csr_wdata <= w_mst_mret;
          end
        end
        S_W_MEPC: begin
          r_state     <= S_W_MCAUSE;
          r_csr_we    <= 1'b1;
          r_csr_waddr <= CSR_MCAUSE;
          r_csr_wdata <= r_cause;
        end
        S_W_MCAUSE: begin
          r_state     <= S_W_MSTATUS;
          r_csr_we    <= 1'b1;
          r_csr_waddr <= CSR_MSTATUS;
          r_csr_wdata <= w_mst_trap;
        end
        S_W_MSTATUS: begin
          r_state      <= S_ASSERT;
          r_int_assert <= 1'b1;
          r_int_addr   <= w_trap_tgt;
          r_irq_ack    <= w_ack;
        end
        S_W_MRET: begin
          r_state      <= S_ASSERT;
          r_int_assert <= 1'b1;
          r_int_addr   <= csr_mepc_i;
        end
        S_ASSERT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign csr_we_o     = r_csr_we;
  assign csr_waddr_o  = r_csr_waddr;
  assign csr_wdata_o  = r_csr_wdata;
  assign int_assert_o = r_int_assert;
  assign int_addr_o   = r_int_addr;
  assign irq_ack_o    = r_irq_ack;

  logic unused_epc;
  assign unused_epc = ^r_epc;

endmodule

// File: tb/tb_clint_arb.sv
// Randomized bench for clint_arb: each request is scored cycle by cycle against a
// timeline derived from the trap/MRET rules, plus directed corner cases.
module tb_clint_arb;

  localparam int unsigned N = 4;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] irq, irq_en;
  logic         iv;
  logic [31:0]  inst, iaddr;
  logic         jf;
  logic [31:0]  jaddr, mtvec, mepc, mst;
  logic         hold, we, ias;
  logic [11:0]  waddr;
  logic [31:0]  wdata, iaddr_o;
  logic [N-1:0] ack;

  always #5 clk = ~clk;

  clint_arb #(.NUM_IRQ(N), .XLEN(32), .CAUSE_BASE(16), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_en_i(irq_en),
    .inst_valid_i(iv), .inst_i(inst), .inst_addr_i(iaddr),
    .jump_flag_i(jf), .jump_addr_i(jaddr), .csr_mtvec_i(mtvec),
    .csr_mepc_i(mepc), .csr_mstatus_i(mst), .hold_o(hold),
    .csr_we_o(we), .csr_waddr_o(waddr), .csr_wdata_o(wdata),
    .int_assert_o(ias), .int_addr_o(iaddr_o), .irq_ack_o(ack)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: 0 none, 1 sync trap, 2 async trap, 3 mret
  int          m_kind;
  logic [31:0] m_epc, m_cause, m_tgt, m_mst_w;
  logic [N-1:0] m_ack;

  logic [31:0] obs_mepc, obs_mcause, obs_mst, obs_addr;
  logic [N-1:0] obs_ack;
  int          obs_hold;

  task automatic model();
    logic [N-1:0] pend;
    int k;
    logic [31:0] code;
    pend = irq & irq_en;
    k = 0;
    for (int i = N - 1; i >= 0; i--) if (pend[i]) k = i;
    m_ack = '0;
    if (iv && (inst == ECALL || inst == EBREAK)) begin
      m_kind  = 1;
      code    = (inst == ECALL) ? 32'd11 : 32'd3;
      m_cause = code;
      m_epc   = iaddr;
      m_tgt   = mtvec & ~32'h3;
    end else if (mst[3] && pend != 0) begin
      m_kind  = 2;
      code    = 32'(16 + k);
      m_cause = 32'h8000_0000 | code;
      m_epc   = jf ? jaddr : iaddr;
      m_tgt   = (mtvec & ~32'h3) + ((mtvec[1:0] == 2'b01) ? code * 4 : 32'd0);
      m_ack   = N'(1 << k);
    end else if (iv && inst == MRET) begin
      m_kind = 3;
      m_tgt  = mepc;
    end else begin
      m_kind = 0;
    end
    if (m_kind == 3) m_mst_w = (mst & ~32'h8) | (mst[7] ? 32'h8 : 32'h0) | 32'h80;
    else             m_mst_w = (mst & ~32'h88) | (mst[3] ? 32'h80 : 32'h0);
  endtask

  task automatic run_txn(input string name, input logic s_iv, input logic [31:0] s_inst,
                         input logic [31:0] s_addr, input logic s_jf, input logic [31:0] s_ja,
                         input logic [N-1:0] s_irq, input logic [N-1:0] s_en,
                         input logic [31:0] s_mtvec, input logic [31:0] s_mepc,
                         input logic [31:0] s_mst);
    int len;
    logic e_hold, e_we, e_as;
    logic [11:0] e_wa;
    logic [31:0] e_wd, e_ia;
    logic [N-1:0] e_ack;
    @(negedge clk);
    iv = s_iv; inst = s_inst; iaddr = s_addr; jf = s_jf; jaddr = s_ja;
    irq = s_irq; irq_en = s_en; mtvec = s_mtvec; mepc = s_mepc; mst = s_mst;
    model();
    len = (m_kind == 1 || m_kind == 2) ? 5 : (m_kind == 3) ? 3 : 1;
    obs_mepc = '0; obs_mcause = '0; obs_mst = '0; obs_addr = '0; obs_ack = '0; obs_hold = 0;
    for (int c = 0; c <= len; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) begin iv = 1'b0; irq = '0; jf = 1'b0; end
      #1;
      e_hold = (m_kind != 0) && (c < len);
      e_we = 1'b0; e_wa = '0; e_wd = '0; e_as = 1'b0; e_ia = '0; e_ack = '0;
      if (m_kind == 1 || m_kind == 2) begin
        case (c)
          1: begin e_we = 1'b1; e_wa = 12'h341; e_wd = m_epc;   end
          2: begin e_we = 1'b1; e_wa = 12'h342; e_wd = m_cause; end
          3: begin e_we = 1'b1; e_wa = 12'h300; e_wd = m_mst_w; end
          4: begin e_as = 1'b1; e_ia = m_tgt; e_ack = m_ack;   end
          default: ;
        endcase
      end else if (m_kind == 3) begin
        if (c == 1) begin e_we = 1'b1; e_wa = 12'h300; e_wd = m_mst_w; end
        if (c == 2) begin e_as = 1'b1; e_ia = m_tgt; end
      end
      check({name, ".hold"},  32'(hold),    32'(e_hold));
      check({name, ".we"},    32'(we),      32'(e_we));
      check({name, ".waddr"}, 32'(waddr),   32'(e_wa));
      check({name, ".wdata"}, wdata,        e_wd);
      check({name, ".assert"},32'(ias),     32'(e_as));
      check({name, ".addr"},  iaddr_o,      e_ia);
      check({name, ".ack"},   32'(ack),     32'(e_ack));
      if (hold) obs_hold++;
      if (we && waddr == 12'h341) obs_mepc = wdata;
      if (we && waddr == 12'h342) obs_mcause = wdata;
      if (we && waddr == 12'h300) obs_mst = wdata;
      if (ias) begin obs_addr = iaddr_o; obs_ack = ack; end
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".hold"},  32'(hold),  32'd0);
    check({name, ".we"},    32'(we),    32'd0);
    check({name, ".waddr"}, 32'(waddr), 32'd0);
    check({name, ".wdata"}, wdata,      32'd0);
    check({name, ".assert"},32'(ias),   32'd0);
    check({name, ".addr"},  iaddr_o,    32'd0);
    check({name, ".ack"},   32'(ack),   32'd0);
  endtask

  initial begin
    logic [31:0] r_inst, r_mtvec;
    logic        r_iv;
    rst_n = 1'b0; iv = 1'b0; inst = '0; iaddr = '0; jf = 1'b0; jaddr = '0;
    irq = '0; irq_en = '0; mtvec = '0; mepc = '0; mst = '0;
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    run_txn("ecall", 1'b1, ECALL, 32'h100, 1'b0, 32'h0, 4'b0000, 4'b0000, 32'h200, 32'h0, 32'h8);
    check("ecall.mepc",   obs_mepc,   32'h100);
    check("ecall.mcause", obs_mcause, 32'd11);
    check("ecall.mst",    obs_mst,    32'h80);
    check("ecall.target", obs_addr,   32'h200);
    check("ecall.holdcyc", 32'(obs_hold), 32'd5);

    run_txn("irq_direct", 1'b0, 32'h13, 32'h400, 1'b0, 32'h0, 4'b0110, 4'b1111, 32'h200, 32'h0, 32'h8);
    check("irq_direct.mcause", obs_mcause, 32'h8000_0011);
    check("irq_direct.ack",    32'(obs_ack), 32'b0010);
    check("irq_direct.target", obs_addr,   32'h200);

    run_txn("irq_vec", 1'b0, 32'h13, 32'h400, 1'b0, 32'h0, 4'b0110, 4'b1111, 32'h201, 32'h0, 32'h8);
    check("irq_vec.target", obs_addr, 32'h244);

    run_txn("ebreak_vec", 1'b1, EBREAK, 32'h180, 1'b0, 32'h0, 4'b0000, 4'b0000, 32'h201, 32'h0, 32'h8);
    check("ebreak_vec.mcause", obs_mcause, 32'd3);
    check("ebreak_vec.target", obs_addr,   32'h200);

    run_txn("mret", 1'b1, MRET, 32'h500, 1'b0, 32'h0, 4'b0000, 4'b0000, 32'h200, 32'h104, 32'h80);
    check("mret.mst",    obs_mst,  32'h88);
    check("mret.target", obs_addr, 32'h104);

    run_txn("irq_mie0", 1'b0, 32'h13, 32'h400, 1'b0, 32'h0, 4'b0001, 4'b1111, 32'h200, 32'h0, 32'h0);
    check("irq_mie0.holdcyc", 32'(obs_hold), 32'd0);
    run_txn("irq_en0", 1'b0, 32'h13, 32'h400, 1'b0, 32'h0, 4'b0001, 4'b0000, 32'h200, 32'h0, 32'h8);
    check("irq_en0.holdcyc", 32'(obs_hold), 32'd0);

    run_txn("ecall_vs_irq", 1'b1, ECALL, 32'h120, 1'b0, 32'h0, 4'b1000, 4'b1111, 32'h201, 32'h0, 32'h8);
    check("ecall_vs_irq.mcause", obs_mcause, 32'd11);
    check("ecall_vs_irq.ack",    32'(obs_ack), 32'd0);

    run_txn("irq_jump", 1'b1, 32'h13, 32'h140, 1'b1, 32'h300, 4'b0100, 4'b0100, 32'h200, 32'h0, 32'h8);
    check("irq_jump.mepc", obs_mepc, 32'h300);

    run_txn("vec_wrap", 1'b0, 32'h13, 32'h10, 1'b0, 32'h0, 4'b0001, 4'b0001, 32'hFFFF_FFF1, 32'h0, 32'h8);
    check("vec_wrap.target", obs_addr, 32'h30);

    // Reset while the mcause write is on the port.
    @(negedge clk);
    iv = 1'b1; inst = ECALL; iaddr = 32'h100; mtvec = 32'h200; mst = 32'h8;
    @(negedge clk); iv = 1'b0;
    @(negedge clk); #1;
    check("midrst.waddr", 32'(waddr), 32'h342);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_all_zero("midrst");
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      check("midrst.no_we",     32'(we),  32'd0);
      check("midrst.no_assert", 32'(ias), 32'd0);
    end

    for (int t = 0; t < 250; t++) begin
      case ($urandom_range(0, 4))
        0: r_inst = ECALL;
        1: r_inst = EBREAK;
        2: r_inst = MRET;
        default: r_inst = $urandom;
      endcase
      r_iv    = 1'($urandom_range(0, 1));
      r_mtvec = $urandom;
      if ($urandom_range(0, 1) == 1) r_mtvec = (r_mtvec & ~32'h3) | 32'h1;
      run_txn("rand", r_iv, r_inst, $urandom, 1'($urandom_range(0, 1)), $urandom,
              N'($urandom), N'($urandom), r_mtvec, $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
